alu_exec_stage: RTL and testbench
=================================

// Module: alu_exec_stage
// PURPOSE
//  Registered execute stage of the core datapath. Accepts decoded operand pairs and an ALU opcode,
//  computes the result (including signed SLT and unsigned SLTU compares, zero-extended to 32 bits),
//  and presents it to writeback through a valid/ready handshake. A 2-entry output buffer
//  (output register plus skid register) absorbs writeback stalls with no bubbles and no drops.
// PARAMETERS
//  WIDTH     32  operand/result width (SLT/SLTU results zero-extended to WIDTH)
//  TAG_W     5   destination-register tag width, carried unmodified alongside the result
//  CNT_W     32  width of the retired-operation counter
// PORTS
//  clk         in   1       rising-edge clock
//  rst_n       in   1       asynchronous active-low reset
//  in_valid    in   1       upstream presents op/A/B/tag
//  in_ready    out  1       stage accepts this cycle (registered)
//  in_op       in   4       0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 NOR,6 SLT,7 SLTU,8 SLL,9 SRL,10 SRA,11 LUI
//  in_a        in   WIDTH   operand A (shift amount source for 8-10 is B[4:0], shifted value is A)
//  in_b        in   WIDTH   operand B
//  in_tag      in   TAG_W   destination tag
//  out_valid   out  1       result available
//  out_ready   in   1       writeback consumes
//  out_result  out  WIDTH   result
//  out_tag     out  TAG_W   tag of result
//  out_ovf     out  1       signed overflow (ADD/SUB only, else 0)
//  out_illegal out  1       opcode 12-15: result forced to 0, still delivered
//  retired     out  CNT_W   count of results handed off (out_valid & out_ready), wraps to 0
// BEHAVIOUR
//  - Reset (async, rst_n=0): out_valid=0, in_ready=1, out_result=0, out_tag=0, out_ovf=0,
//    out_illegal=0, retired=0, buffer state EMPTY. Any in-flight/buffered ops are discarded.
//  - Accept = in_valid & in_ready; deliver = out_valid & out_ready.
//  - Compute is combinational on inputs; result captured at accept edge. Latency: accepted at edge N
//    -> out_valid with that result after edge N (visible in cycle N+1).
//  - SLT: result = ($signed(A) < $signed(B)) ? 1 : 0. SLTU: unsigned compare. Upper bits zero.
//  - SLL/SRL/SRA shift A by B[4:0]; SRA sign-fills. LUI: result = {B[15:0],16'h0}. All arithmetic mod 2^WIDTH.
//  - ovf ADD: A,B same sign and result sign differs; SUB: A,B signs differ and result sign != A sign.
//  - Buffer FSM (state held in regs; in_ready = state!=FULL, registered from next state):
//    EMPTY: accept -> ONE (load out reg).
//    ONE:   accept & deliver -> ONE (out reg reloaded); accept & !deliver -> FULL (load skid);
//           !accept & deliver -> EMPTY; else hold.
//    FULL:  deliver -> ONE (skid moves to out reg); no accept possible; else hold.
//  - Ordering strictly FIFO; out_result/out_tag/flags stable while out_valid & !out_ready.
//  - Simultaneous accept & deliver in ONE: no bubble, throughput 1/cycle.
//  - retired increments on each deliver, wraps from 2^CNT_W-1 to 0.
//  - in_valid while in_ready=0: inputs ignored, upstream must hold.
// TESTING
//  1 SLT A=0,B=20 -> out_result=1 next cycle; A=20,B=15 -> 0; A=20,B=20 -> 0; tags preserved.
//  2 SLT A=0xFFFFFFFF,B=1 -> 1; SLTU same operands -> 0; A=185220,B=225571 SLT -> 1.
//  3 ADD 0x7FFFFFFF+1 -> 0x80000000, out_ovf=1; SUB 0x80000000-1 -> 0x7FFFFFFF, ovf=1; SRA 0x80000000>>4 -> 0xF8000000.
//  4 out_ready=0, in_valid=1 with ops T1,T2,T3 -> T1,T2 accepted, in_ready=0 holds T3; release
//    out_ready -> T1,T2,T3 delivered in order, one per cycle, retired=3.
//  5 Stream 8 ops with out_ready=1 -> 8 results on consecutive cycles, in_ready never drops.
//  6 Assert rst_n=0 mid-stream in FULL -> out_valid=0, in_ready=1, retired=0 immediately (async);
//    opcode 13 after reset -> out_result=0, out_illegal=1.

Source files
------------

// File: rtl/alu_exec_stage.sv
// Registered ALU execute stage with a 2-entry (output + skid) result buffer.
// Results are computed combinationally from the inputs and captured on accept.
// They are handed to writeback over a valid/ready handshake in strict FIFO order.
module alu_exec_stage #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 5,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_ovf,
  output logic             out_illegal,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [1:0] {StEmpty, StOne, StFull} buf_state_e;

  buf_state_e state_q, state_d;

  logic             in_ready_q, out_valid_q;
  logic [WIDTH-1:0] res_q, skid_res_q;
  logic [TAG_W-1:0] tag_q, skid_tag_q;
  logic             ovf_q, skid_ovf_q;
  logic             ill_q, skid_ill_q;
  logic [CNT_W-1:0] retired_q;

  logic             accept, deliver;
  logic             load_out, load_skid, skid_to_out;

  logic [WIDTH-1:0]        alu_res;
  logic                    alu_ovf, alu_ill;
  logic [WIDTH-1:0]        sum, diff;
  logic signed [WIDTH-1:0] sra_res;
  logic [4:0]              shamt;

  assign accept  = in_valid & in_ready_q;
  assign deliver = out_valid_q & out_ready;

  assign sum     = in_a + in_b;
  assign diff    = in_a - in_b;
  assign shamt   = in_b[4:0];
  assign sra_res = $signed(in_a) >>> shamt;

  // ALU result, overflow and illegal-opcode flag for the operands presented this cycle
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_ill = 1'b0;
    case (in_op)
      4'd0: begin
        alu_res = sum;
        alu_ovf = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (sum[WIDTH-1] != in_a[WIDTH-1]);
      end
      4'd1: begin
        alu_res = diff;
        alu_ovf = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (diff[WIDTH-1] != in_a[WIDTH-1]);
      end
      4'd2:    alu_res = in_a & in_b;
      4'd3:    alu_res = in_a | in_b;
      4'd4:    alu_res = in_a ^ in_b;
      4'd5:    alu_res = ~(in_a | in_b);
      4'd6:    alu_res = {{(WIDTH-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
      4'd7:    alu_res = {{(WIDTH-1){1'b0}}, (in_a < in_b)};
      4'd8:    alu_res = in_a << shamt;
      4'd9:    alu_res = in_a >> shamt;
      4'd10:   alu_res = sra_res;
      4'd11:   alu_res = WIDTH'({in_b[15:0], 16'h0000});
      default: alu_ill = 1'b1;  // result stays zero but is still delivered
    endcase
  end

  // Buffer occupancy transitions and which register gets loaded
  always_comb begin
    state_d     = state_q;
    load_out    = 1'b0;
    load_skid   = 1'b0;
    skid_to_out = 1'b0;
    case (state_q)
      StEmpty: begin
        if (accept) begin
          state_d  = StOne;
          load_out = 1'b1;
        end
      end
      StOne: begin
        if (accept && deliver) begin
          load_out = 1'b1;
        end else if (accept) begin
          state_d   = StFull;
          load_skid = 1'b1;
        end else if (deliver) begin
          state_d = StEmpty;
        end
      end
      StFull: begin
        // in_ready is low here, so no accept can coincide
        if (deliver) begin
          state_d     = StOne;
          skid_to_out = 1'b1;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  // Buffer registers, handshake flags and retired counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StEmpty;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      tag_q       <= '0;
      ovf_q       <= 1'b0;
      ill_q       <= 1'b0;
      skid_res_q  <= '0;
      skid_tag_q  <= '0;
      skid_ovf_q  <= 1'b0;
      skid_ill_q  <= 1'b0;
      retired_q   <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != StFull);
      out_valid_q <= (state_d != StEmpty);
      if (load_out) begin
        res_q <= alu_res;
        tag_q <= in_tag;
        ovf_q <= alu_ovf;
        ill_q <= alu_ill;
      end else if (skid_to_out) begin
        res_q <= skid_res_q;
        tag_q <= skid_tag_q;
        ovf_q <= skid_ovf_q;
        ill_q <= skid_ill_q;
      end
      if (load_skid) begin
        skid_res_q <= alu_res;
        skid_tag_q <= in_tag;
        skid_ovf_q <= alu_ovf;
        skid_ill_q <= alu_ill;
      end
      if (deliver) begin
        retired_q <= retired_q + CNT_W'(1);
      end
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_result  = res_q;
  assign out_tag     = tag_q;
  assign out_ovf     = ovf_q;
  assign out_illegal = ill_q;
  assign retired     = retired_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Bench for alu_exec_stage: directed cases with literal expectations plus a randomized
// phase, all cross-checked every cycle against a queue-based model of the stage.
module tb_alu_exec_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [3:0]  in_op;
  logic [31:0] in_a, in_b;
  logic [4:0]  in_tag;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_tag;
  logic        out_ovf, out_illegal;
  logic [31:0] retired;

  alu_exec_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag),
    .out_ovf    (out_ovf),
    .out_illegal(out_illegal),
    .retired    (retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  tag;
    logic        ovf;
    logic        ill;
  } exp_t;

  int checks = 0;
  int failures = 0;
  int stalls = 0;

  exp_t        mq[$];       // results the stage currently holds, oldest first
  logic [31:0] m_retired;
  int          cyc;
  logic [4:0]  del_tags[$];
  int          del_cyc[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference ALU from arithmetic on 64-bit signed/unsigned values
  function automatic exp_t ref_alu(input logic [3:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input logic [4:0] tag);
    exp_t e;
    longint          sa, sb, s;
    longint unsigned ua, ub, u;
    int              sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    sh = int'(b[4:0]);
    e.res = '0;
    e.tag = tag;
    e.ovf = 1'b0;
    e.ill = 1'b0;
    case (op)
      4'd0: begin s = sa + sb; e.res = s[31:0]; e.ovf = (s[32] != s[31]); end
      4'd1: begin s = sa - sb; e.res = s[31:0]; e.ovf = (s[32] != s[31]); end
      4'd2: e.res = a & b;
      4'd3: e.res = a | b;
      4'd4: e.res = a ^ b;
      4'd5: e.res = ~(a | b);
      4'd6: e.res = (sa < sb) ? 32'd1 : 32'd0;
      4'd7: e.res = (ua < ub) ? 32'd1 : 32'd0;
      4'd8: begin u = ua << sh; e.res = u[31:0]; end
      4'd9: begin u = ua >> sh; e.res = u[31:0]; end
      4'd10: begin s = sa >>> sh; e.res = s[31:0]; end
      4'd11: begin u = ub * 64'd65536; e.res = u[31:0]; end
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  // Model: accept when fewer than two results are held, deliver the oldest when ready
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_retired = '0;
      del_tags.delete();
      del_cyc.delete();
      cyc = 0;
    end else begin
      bit acc, del;
      acc = in_valid && (mq.size() < 2);
      del = (mq.size() > 0) && out_ready;
      cyc++;
      if (del) begin
        del_tags.push_back(mq[0].tag);
        del_cyc.push_back(cyc);
        void'(mq.pop_front());
        m_retired = m_retired + 32'd1;
      end
      if (acc) mq.push_back(ref_alu(in_op, in_a, in_b, in_tag));
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (rst_n) begin
      check("out_valid", 64'(out_valid), 64'(mq.size() > 0));
      check("in_ready", 64'(in_ready), 64'(mq.size() < 2));
      check("retired", 64'(retired), 64'(m_retired));
      if (mq.size() > 0 && out_valid) begin
        check("out_result", 64'(out_result), 64'(mq[0].res));
        check("out_tag", 64'(out_tag), 64'(mq[0].tag));
        check("out_ovf", 64'(out_ovf), 64'(mq[0].ovf));
        check("out_illegal", 64'(out_illegal), 64'(mq[0].ill));
      end
    end
  end

  // Present one op and hold it until accepted; returns aligned at posedge+1
  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] tag);
    bit rdy;
    int n;
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
    n = 0;
    do begin
      @(negedge clk);
      rdy = in_ready;
      if (!rdy) stalls++;
      @(posedge clk);
      #1;
      n++;
    end while (!rdy && n < 60);
    if (!rdy) check("send_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
  endtask

  // Single op into an empty stage with out_ready=1, literal expectation next cycle
  task automatic op_check(input string name, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] tag,
                          input logic [31:0] res, input logic ovf, input logic ill);
    send(op, a, b, tag);
    @(negedge clk);
    check({name, "_valid"}, 64'(out_valid), 64'd1);
    check({name, "_result"}, 64'(out_result), 64'(res));
    check({name, "_tag"}, 64'(out_tag), 64'(tag));
    check({name, "_ovf"}, 64'(out_ovf), 64'(ovf));
    check({name, "_illegal"}, 64'(out_illegal), 64'(ill));
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset pulse mid-cycle, checked before any clock edge
  task automatic pulse_reset(input string name);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check({name, "_out_valid"}, 64'(out_valid), 64'd0);
    check({name, "_in_ready"}, 64'(in_ready), 64'd1);
    check({name, "_retired"}, 64'(retired), 64'd0);
    check({name, "_result"}, 64'(out_result), 64'd0);
    check({name, "_tag"}, 64'(out_tag), 64'd0);
    check({name, "_ovf_ill"}, 64'({out_ovf, out_illegal}), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 4))
      0: return 32'h8000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'($urandom_range(0, 40));
      3: return 32'hFFFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  initial begin
    int n0, s0;
    bit rdy;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_op     = '0;
    in_a      = '0;
    in_b      = '0;
    in_tag    = '0;
    out_ready = 1'b1;
    #12;
    pulse_reset("reset");

    // Signed/unsigned compares, tags carried through
    op_check("slt_0_20", 4'd6, 32'd0, 32'd20, 5'd1, 32'd1, 1'b0, 1'b0);
    op_check("slt_20_15", 4'd6, 32'd20, 32'd15, 5'd2, 32'd0, 1'b0, 1'b0);
    op_check("slt_20_20", 4'd6, 32'd20, 32'd20, 5'd3, 32'd0, 1'b0, 1'b0);
    op_check("slt_neg1_1", 4'd6, 32'hFFFF_FFFF, 32'd1, 5'd4, 32'd1, 1'b0, 1'b0);
    op_check("sltu_neg1_1", 4'd7, 32'hFFFF_FFFF, 32'd1, 5'd5, 32'd0, 1'b0, 1'b0);
    op_check("slt_big", 4'd6, 32'd185220, 32'd225571, 5'd6, 32'd1, 1'b0, 1'b0);
    // Overflow and arithmetic shift boundaries
    op_check("add_ovf", 4'd0, 32'h7FFF_FFFF, 32'd1, 5'd7, 32'h8000_0000, 1'b1, 1'b0);
    op_check("sub_ovf", 4'd1, 32'h8000_0000, 32'd1, 5'd8, 32'h7FFF_FFFF, 1'b1, 1'b0);
    op_check("sra", 4'd10, 32'h8000_0000, 32'd4, 5'd9, 32'hF800_0000, 1'b0, 1'b0);
    op_check("lui", 4'd11, 32'h0, 32'h0001_ABCD, 5'd10, 32'hABCD_0000, 1'b0, 1'b0);
    op_check("nor", 4'd5, 32'h0F0F_0000, 32'h0000_00FF, 5'd11, 32'hF0F0_FF00, 1'b0, 1'b0);

    // Writeback stall: two accepted, third held, then drained in order
    pulse_reset("reset2");
    out_ready = 1'b0;
    fork
      begin
        send(4'd0, 32'd1, 32'd2, 5'd11);
        send(4'd0, 32'd3, 32'd4, 5'd12);
        send(4'd0, 32'd5, 32'd6, 5'd13);
      end
      begin
        repeat (4) @(negedge clk);
        check("stall_in_ready", 64'(in_ready), 64'd0);
        check("stall_out_tag", 64'(out_tag), 64'd11);
        check("stall_out_result", 64'(out_result), 64'd3);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    repeat (3) @(posedge clk);
    #1;
    check("drain_count", 64'(del_tags.size()), 64'd3);
    if (del_tags.size() == 3) begin
      check("drain_t1", 64'(del_tags[0]), 64'd11);
      check("drain_t2", 64'(del_tags[1]), 64'd12);
      check("drain_t3", 64'(del_tags[2]), 64'd13);
      check("drain_back2back", 64'(del_cyc[2] - del_cyc[0]), 64'd2);
    end
    check("drain_retired", 64'(retired), 64'd3);

    // Full-throughput stream of 8 ops
    n0 = del_tags.size();
    s0 = stalls;
    for (int i = 0; i < 8; i++) begin
      send(4'($urandom_range(0, 11)), $urandom(), $urandom(), 5'(i + 16));
    end
    @(posedge clk);
    #1;
    check("stream_no_stall", 64'(stalls - s0), 64'd0);
    check("stream_count", 64'(del_tags.size() - n0), 64'd8);
    if (del_tags.size() == n0 + 8) begin
      check("stream_consecutive", 64'(del_cyc[n0 + 7] - del_cyc[n0]), 64'd7);
      check("stream_last_tag", 64'(del_tags[n0 + 7]), 64'd23);
    end

    // Reset while FULL, then an illegal opcode
    out_ready = 1'b0;
    send(4'd2, 32'hFF, 32'h0F, 5'd1);
    send(4'd3, 32'hF0, 32'h0F, 5'd2);
    @(negedge clk);
    check("full_in_ready", 64'(in_ready), 64'd0);
    pulse_reset("reset_full");
    out_ready = 1'b1;
    op_check("illegal13", 4'd13, 32'h1234_5678, 32'h9ABC_DEF0, 5'd30, 32'd0, 1'b0, 1'b1);

    // Randomized traffic with the protocol's hold rule on stalled inputs
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
      if (!(in_valid && !rdy)) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_op    = 4'($urandom_range(0, 15));
        in_a     = rand_operand();
        in_b     = rand_operand();
        in_tag   = 5'($urandom());
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("final_empty", 64'(out_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
